// File: rtl/psum_gbf_loader_pkg.sv
// psum_loader_pkg: shared types and constants for the psum GBF loader.
//   - state_t    : top-level loader FSM states
//   - LANES      : psum lanes per GBF word (512 / 16)
//   - NRF        : psum RF depth, i.e. GBF words fetched per load
//   - LANE_W     : width of a stored lane index
//   - GBF_AW     : psum GBF address width
//   - cfg_legal(): start-time configuration check
package psum_loader_pkg;

    localparam int LANES  = 32;
    localparam int NRF    = 4;
    localparam int LANE_W = 5;
    localparam int GBF_AW = 5;

    typedef enum logic [2:0] {
        IDLE,
        MAP,
        RD,
        WT,
        WR,
        DONE
    } state_t;

    // A group must have at least one PE, at least one group must exist, every
    // group needs its own lane, and all groups must fit in the PE array.
    function automatic logic cfg_legal(input logic [LANE_W-1:0] irrel,
                                       input logic [LANE_W-1:0] rel,
                                       input int                npe);
        logic ok;
        ok = 1'b1;
        if (irrel == '0)                        ok = 1'b0;
        if (rel == '0)                          ok = 1'b0;
        if (int'(rel) > LANES)                  ok = 1'b0;
        if (int'(irrel) * int'(rel) > npe)      ok = 1'b0;
        return ok;
    endfunction

endpackage

// File: rtl/psum_lane_mapper.sv
// psum_lane_mapper: builds the per-PE routing table used when psums are
// scattered back from the GBF into the PE array.
// Ports:
//   clk, reset     : clock, synchronous active-low reset
//   start          : accepted-start pulse; captures irrel_num/rel_num
//   irrel_num      : PEs per irrelevant group
//   rel_num        : number of relevant groups (lanes in use)
//   map_done       : high in the cycle the last PE entry is written
//   lane_vec       : LANE_W-bit lane index per PE, PE p at [LANE_W*p +: LANE_W]
//   lead_vec       : 1 for PEs that lead a routed group
module psum_lane_mapper
    import psum_loader_pkg::*;
#(
    parameter int NPE = 256
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [LANE_W-1:0]     irrel_num,
    input  logic [LANE_W-1:0]     rel_num,
    output logic                  map_done,
    output logic [NPE*LANE_W-1:0] lane_vec,
    output logic [NPE-1:0]        lead_vec
);

    localparam int PW    = $clog2(NPE);
    localparam int GRP_W = PW + 1;

    logic                  active_q, active_d;
    logic [PW-1:0]         p_q, p_d;
    logic [LANE_W-1:0]     ing_q, ing_d;
    logic [GRP_W-1:0]      grp_q, grp_d;
    logic [LANE_W-1:0]     irrel_q, irrel_d;
    logic [LANE_W-1:0]     rel_q, rel_d;
    logic [NPE*LANE_W-1:0] lane_q, lane_d;
    logic [NPE-1:0]        lead_q, lead_d;

    // In-group / group counters replace p / irrel_num and p % irrel_num, so
    // no divider is needed; one PE entry is written per cycle.
    always_comb begin
        active_d = active_q;
        p_d      = p_q;
        ing_d    = ing_q;
        grp_d    = grp_q;
        irrel_d  = irrel_q;
        rel_d    = rel_q;
        lane_d   = lane_q;
        lead_d   = lead_q;
        if (start) begin
            active_d = 1'b1;
            p_d      = '0;
            ing_d    = '0;
            grp_d    = '0;
            irrel_d  = irrel_num;
            rel_d    = rel_num;
        end else if (active_q) begin
            lane_d[p_q*LANE_W +: LANE_W] = grp_q[LANE_W-1:0];
            lead_d[p_q] = (ing_q == '0) && (grp_q < GRP_W'(rel_q));
            if (ing_q == irrel_q - LANE_W'(1)) begin
                ing_d = '0;
                grp_d = grp_q + GRP_W'(1);
            end else begin
                ing_d = ing_q + LANE_W'(1);
            end
            p_d = p_q + PW'(1);
            if (p_q == PW'(NPE - 1)) begin
                active_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            active_q <= 1'b0;
            p_q      <= '0;
            ing_q    <= '0;
            grp_q    <= '0;
            irrel_q  <= '0;
            rel_q    <= '0;
            lane_q   <= '0;
            lead_q   <= '0;
        end else begin
            active_q <= active_d;
            p_q      <= p_d;
            ing_q    <= ing_d;
            grp_q    <= grp_d;
            irrel_q  <= irrel_d;
            rel_q    <= rel_d;
            lane_q   <= lane_d;
            lead_q   <= lead_d;
        end
    end

    assign map_done = active_q && (p_q == PW'(NPE - 1));
    assign lane_vec = lane_q;
    assign lead_vec = lead_q;

endmodule

// File: rtl/psum_gbf_loader.sv
// psum_gbf_loader: reads reduced psums back from the psum GBF (one word per
// psum-RF address) and scatters them into the PE-array psum RFs. Only the
// leader of each irrelevant group receives the stored value; others get 0.
// Ports:
//   clk, reset          : clock, synchronous active-low reset
//   load_start          : start pulse, honoured only in IDLE
//   irrel_num, rel_num  : group size / group count, sampled at start
//   base_addr           : first GBF word address, sampled at start
//   psum_gbf_r_en/addr  : GBF read request
//   psum_gbf_r_data     : GBF read data, one cycle after r_en
//   psum_in             : per-PE psum, PE p at [DATA_BITWIDTH*p +: DATA_BITWIDTH]
//   psum_rf_w_en/addr   : PE psum RF write strobe and address
//   load_busy           : load in progress
//   load_finish         : one-cycle completion pulse
//   cfg_err             : one-cycle pulse after a rejected start
module psum_gbf_loader
    import psum_loader_pkg::*;
#(
    parameter int ROW                   = 16,
    parameter int COL                   = 16,
    parameter int DATA_BITWIDTH         = 16,
    parameter int GBF_DATA_BITWIDTH     = 512,
    parameter int PSUM_RF_ADDR_BITWIDTH = 2,
    parameter int DEPTH                 = 32
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 load_start,
    input  logic [LANE_W-1:0]                    irrel_num,
    input  logic [LANE_W-1:0]                    rel_num,
    input  logic [GBF_AW-1:0]                    base_addr,
    output logic                                 psum_gbf_r_en,
    output logic [GBF_AW-1:0]                    psum_gbf_r_addr,
    input  logic [GBF_DATA_BITWIDTH-1:0]         psum_gbf_r_data,
    output logic [DATA_BITWIDTH*ROW*COL-1:0]     psum_in,
    output logic                                 psum_rf_w_en,
    output logic [PSUM_RF_ADDR_BITWIDTH-1:0]     psum_rf_addr,
    output logic                                 load_busy,
    output logic                                 load_finish,
    output logic                                 cfg_err
);

    localparam int NPE = ROW * COL;
    localparam int AW  = PSUM_RF_ADDR_BITWIDTH;

    state_t                         state_q, state_d;
    logic [AW-1:0]                  a_q, a_d;
    logic [GBF_AW-1:0]              base_q, base_d;
    logic [GBF_DATA_BITWIDTH-1:0]   word_q, word_d;
    logic                           cfg_err_q, cfg_err_d;
    logic                           map_start;
    logic                           map_done;
    logic [NPE*LANE_W-1:0]          lane_vec;
    logic [NPE-1:0]                 lead_vec;
    logic [LANE_W-1:0]              lane_sel;

    psum_lane_mapper #(
        .NPE (NPE)
    ) u_mapper (
        .clk       (clk),
        .reset     (reset),
        .start     (map_start),
        .irrel_num (irrel_num),
        .rel_num   (rel_num),
        .map_done  (map_done),
        .lane_vec  (lane_vec),
        .lead_vec  (lead_vec)
    );

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        base_d    = base_q;
        word_d    = word_q;
        cfg_err_d = 1'b0;
        map_start = 1'b0;
        case (state_q)
            IDLE: begin
                if (load_start) begin
                    if (cfg_legal(irrel_num, rel_num, NPE)) begin
                        state_d   = MAP;
                        a_d       = '0;
                        base_d    = base_addr;
                        map_start = 1'b1;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            MAP: begin
                if (map_done) begin
                    state_d = RD;
                end
            end
            RD: state_d = WT;
            WT: begin
                // Read data is valid during WT, one cycle after the request.
                word_d  = psum_gbf_r_data;
                state_d = WR;
            end
            WR: begin
                if (a_q == AW'(NRF - 1)) begin
                    state_d = DONE;
                end else begin
                    a_d     = a_q + AW'(1);
                    state_d = RD;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            a_q       <= '0;
            base_q    <= '0;
            word_q    <= '0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            base_q    <= base_d;
            word_q    <= word_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    always_comb begin
        psum_gbf_r_en   = (state_q == RD);
        psum_gbf_r_addr = '0;
        if (state_q == RD) begin
            psum_gbf_r_addr = GBF_AW'((int'(base_q) + int'(a_q)) % DEPTH);
        end
        psum_rf_w_en = (state_q == WR);
        psum_rf_addr = (state_q == WR) ? a_q : '0;
        load_busy    = (state_q == MAP) || (state_q == RD) ||
                       (state_q == WT)  || (state_q == WR);
        load_finish  = (state_q == DONE);
        cfg_err      = cfg_err_q;
    end

    // Scatter: word_q only changes at the end of WT, so the value presented
    // during WR is settled for the whole write cycle.
    always_comb begin
        psum_in  = '0;
        lane_sel = '0;
        for (int p = 0; p < NPE; p++) begin
            lane_sel = lane_vec[p*LANE_W +: LANE_W];
            if (lead_vec[p]) begin
                psum_in[p*DATA_BITWIDTH +: DATA_BITWIDTH] =
                    word_q[lane_sel*DATA_BITWIDTH +: DATA_BITWIDTH];
            end
        end
    end

endmodule

// File: tb/tb_psum_gbf_loader.sv
module tb_psum_gbf_loader;

    localparam int NPE   = 256;
    localparam int NRF   = 4;
    localparam int DEPTH = 32;
    localparam int LAT   = NPE + 3 * NRF + 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          load_start;
    logic [4:0]    irrel_num, rel_num, base_addr;
    logic          r_en;
    logic [4:0]    r_addr;
    logic [511:0]  r_data;
    logic [4095:0] psum_in;
    logic          w_en;
    logic [1:0]    rf_addr;
    logic          busy, finish, cfg_err;

    logic [511:0]  mem [DEPTH];
    int checks = 0;
    int errors = 0;

    typedef struct {
        int irrel;
        int rel;
        int base;
        bit exp_err;
        int exp_fin;
        int inj;
        int mode;
    } vec_t;

    vec_t vecs [8];

    always #5 clk = ~clk;

    psum_gbf_loader dut (
        .clk             (clk),
        .reset           (reset),
        .load_start      (load_start),
        .irrel_num       (irrel_num),
        .rel_num         (rel_num),
        .base_addr       (base_addr),
        .psum_gbf_r_en   (r_en),
        .psum_gbf_r_addr (r_addr),
        .psum_gbf_r_data (r_data),
        .psum_in         (psum_in),
        .psum_rf_w_en    (w_en),
        .psum_rf_addr    (rf_addr),
        .load_busy       (busy),
        .load_finish     (finish),
        .cfg_err         (cfg_err)
    );

    // GBF: data one cycle after r_en, junk otherwise so a mistimed latch shows.
    always @(posedge clk) begin
        if (r_en) r_data <= mem[r_addr];
        else      r_data <= {16{$urandom}};
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Reference: PE p belongs to group p/irrel; only member 0 of a group
    // below rel receives lane (group) of the word at (base+a) mod DEPTH.
    function automatic logic [15:0] exp_pe(input int p, input int a, input int irrel,
                                           input int rel, input int base);
        logic [511:0] w;
        int g;
        g = p / irrel;
        if ((p % irrel) == 0 && g < rel) begin
            w = mem[(base + a) % DEPTH];
            return w[16*g +: 16];
        end
        return 16'h0;
    endfunction

    task automatic fill_mem(input int mode);
        logic [511:0] w;
        for (int ad = 0; ad < DEPTH; ad++) begin
            for (int k = 0; k < 32; k++) begin
                if (mode == 0) w[16*k +: 16] = 16'(16 * ad + k + 1);
                else           w[16*k +: 16] = 16'($urandom);
            end
            mem[ad] = w;
        end
    endtask

    task automatic run_load(input vec_t v, input string tag);
        int nw, nr, fin_cyc, fin_cnt, busy_bad, err_cnt, err_cyc, rbad, bad, first;
        logic [15:0] act_pe, exp_v;
        fill_mem(v.mode);
        @(negedge clk);
        irrel_num  = 5'(v.irrel);
        rel_num    = 5'(v.rel);
        base_addr  = 5'(v.base);
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
        nw = 0; nr = 0; fin_cyc = 0; fin_cnt = 0; busy_bad = 0;
        err_cnt = 0; err_cyc = 0; rbad = 0;
        for (int k = 1; k <= LAT + 20; k++) begin
            if (cfg_err) begin err_cnt++; if (err_cyc == 0) err_cyc = k; end
            if (finish) begin fin_cnt++; if (fin_cyc == 0) fin_cyc = k; end
            if (busy !== (!v.exp_err && k < LAT)) busy_bad++;
            if (r_en) begin
                if (r_addr !== 5'((v.base + nr) % DEPTH)) rbad++;
                nr++;
            end
            if (w_en) begin
                chk({tag, " rf_addr"}, rf_addr, nw);
                bad = 0; first = -1; act_pe = '0; exp_v = '0;
                for (int p = 0; p < NPE; p++) begin
                    if (psum_in[16*p +: 16] !== exp_pe(p, nw, v.irrel, v.rel, v.base)) begin
                        if (first < 0) begin
                            first  = p;
                            act_pe = psum_in[16*p +: 16];
                            exp_v  = exp_pe(p, nw, v.irrel, v.rel, v.base);
                        end
                        bad++;
                    end
                end
                checks++;
                if (bad != 0) begin
                    errors++;
                    $display("FAIL %s psum a=%0d pe=%0d actual=%0d expected=%0d (bad PEs %0d)",
                             tag, nw, first, act_pe, exp_v, bad);
                end
                nw++;
            end
            if (k == v.inj) begin
                load_start = 1'b1;
                irrel_num  = 5'd0;
                base_addr  = 5'(v.base + 9);
            end else if (k == v.inj + 1) begin
                load_start = 1'b0;
            end
            @(negedge clk);
        end
        chk({tag, " finish cycle"}, fin_cyc, v.exp_fin);
        chk({tag, " finish count"}, fin_cnt, v.exp_err ? 0 : 1);
        chk({tag, " reads"}, nr, v.exp_err ? 0 : NRF);
        chk({tag, " writes"}, nw, v.exp_err ? 0 : NRF);
        chk({tag, " r_addr errors"}, rbad, 0);
        chk({tag, " busy errors"}, busy_bad, 0);
        chk({tag, " cfg_err count"}, err_cnt, v.exp_err ? 1 : 0);
        if (v.exp_err) chk({tag, " cfg_err cycle"}, err_cyc, 1);
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, " r_en"}, r_en, 0);
        chk({tag, " r_addr"}, r_addr, 0);
        chk({tag, " w_en"}, w_en, 0);
        chk({tag, " rf_addr"}, rf_addr, 0);
        chk({tag, " busy"}, busy, 0);
        chk({tag, " finish"}, finish, 0);
        chk({tag, " cfg_err"}, cfg_err, 0);
        chk({tag, " psum_in nonzero"}, |psum_in, 0);
    endtask

    initial begin
        vec_t rv;
        int seen, act, rmax;
        reset = 1'b0; load_start = 1'b0;
        irrel_num = '0; rel_num = '0; base_addr = '0;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        reset = 1'b1;

        //            irrel rel base err fin  inj mode
        vecs[0] = '{2,  6,  0,  1'b0, LAT, 0,   0};
        vecs[1] = '{1,  31, 4,  1'b0, LAT, 0,   0};
        vecs[2] = '{2,  6,  30, 1'b0, LAT, 0,   0};
        vecs[3] = '{3,  0,  5,  1'b1, 0,   0,   0};
        vecs[4] = '{16, 17, 0,  1'b1, 0,   0,   0};
        vecs[5] = '{0,  4,  0,  1'b1, 0,   0,   0};
        vecs[6] = '{16, 16, 0,  1'b0, LAT, 100, 1};
        vecs[7] = '{5,  7,  17, 1'b0, LAT, 262, 1};
        for (int i = 0; i < 8; i++) begin
            run_load(vecs[i], $sformatf("vec%0d", i));
        end

        // Reset asserted during the second WR cycle.
        fill_mem(1);
        @(negedge clk);
        irrel_num = 5'd16; rel_num = 5'd16; base_addr = 5'd3; load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
        seen = 0;
        for (int k = 0; k < 400; k++) begin
            if (w_en) seen++;
            if (seen == 2) break;
            @(negedge clk);
        end
        chk("second WR reached", seen, 2);
        reset = 1'b0;
        @(negedge clk);
        check_idle_outputs("midreset");
        reset = 1'b1;
        act = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (r_en || w_en || busy || finish || cfg_err) act++;
        end
        chk("activity after reset", act, 0);
        run_load(vecs[6], "post-reset");

        // Randomised legal configurations.
        for (int i = 0; i < 8; i++) begin
            rv.irrel = $urandom_range(1, 31);
            rmax = NPE / rv.irrel;
            if (rmax > 31) rmax = 31;
            rv.rel     = $urandom_range(1, rmax);
            rv.base    = $urandom_range(0, 31);
            rv.exp_err = 1'b0;
            rv.exp_fin = LAT;
            rv.inj     = (i % 2 == 0) ? $urandom_range(2, LAT - 2) : 0;
            rv.mode    = 1;
            run_load(rv, $sformatf("rand%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
